frame_painter: RTL and testbench
================================

// Module: frame_painter
// PURPOSE
//  Sits downstream of the bird/pillar/crash logic. Turns positions into pixels
//  for the VGA adapter frame buffer.
//  On each frame tick it snapshots bird_y, the three pillar positions and
//  game_over, then raster-scans the whole screen, emitting one (x,y,colour,plot)
//  write per cycle. It pulses done when the scan finishes.
// PARAMETERS
//  SCREEN_W  160  columns painted (x = 0..SCREEN_W-1)
//  SCREEN_H  120  rows painted (y = 0..SCREEN_H-1)
//  BIRD_X    30   fixed left column of bird square
//  BIRD_SZ   6    bird square edge, pixels
//  PILLAR_W  10   pillar width, pixels
//  GAP_H     40   vertical opening in each pillar, pixels
//  GROUND_Y  110  first row of ground band
// PORTS
//  clk          in   1   system clock (CLOCK_50)
//  clr          in   1   synchronous active-high reset
//  frame_tick   in   1   one-cycle start pulse (clk10 domain pulse, already synced)
//  bird_y       in   10  bird top row
//  pillar1_x    in   10  pillar 1 left column (>= SCREEN_W = off-screen)
//  pillar1_y    in   10  pillar 1 gap top row
//  pillar2_x/_y in   10  as pillar 1
//  pillar3_x/_y in   10  as pillar 1
//  game_over    in   1   crash flag from crash detector
//  vga_x        out  8   pixel column
//  vga_y        out  7   pixel row
//  vga_colour   out  3   RGB, 1 bit each
//  vga_plot     out  1   write strobe for vga_x/vga_y/vga_colour
//  busy         out  1   high while a frame is being scanned
//  done         out  1   one-cycle pulse after last pixel of a frame
// BEHAVIOUR
//  Reset (clr=1 at posedge): all outputs 0, FSM=IDLE, counters 0, pending=0.
//   Aborts any frame in progress; vga_plot low the cycle after clr.
//  FSM:
//   IDLE: frame_tick|pending -> LATCH, clear pending.
//   LATCH: one cycle; snapshot all position inputs and game_over; cx=cy=0; busy=1.
//   SCAN: colour for (cx,cy) registered to outputs next cycle with vga_plot=1.
//    cx increments; at SCREEN_W-1 it wraps to 0 and cy increments.
//    After (SCREEN_W-1,SCREEN_H-1) is issued -> FLUSH.
//   FLUSH: last pixel on outputs; next cycle done=1, busy=0 -> IDLE.
//  Latency: first plot 2 cycles after frame_tick.
//   Exactly SCREEN_W*SCREEN_H plot cycles (19200), contiguous, row-major.
//  Inputs changing mid-frame have no effect; only the snapshot is used.
//  frame_tick while busy sets pending (1-deep); extra ticks are dropped.
//   A pending frame starts in the cycle after done.
//  Hit tests use 11-bit unsigned sums, no wrap:
//   bird   : BIRD_X<=x<BIRD_X+BIRD_SZ && bird_y<=y<bird_y+BIRD_SZ
//   pillarN: pN_x<=x<pN_x+PILLAR_W && !(pN_y<=y<pN_y+GAP_H) && y<GROUND_Y
//   ground : y>=GROUND_Y
//   Partially off-screen pillars are clipped naturally. bird_y>=SCREEN_H draws no bird.
//  Colour priority: bird 3'b110 > pillar 3'b010 > ground 3'b100 > sky 3'b001.
//  vga_x/vga_y/vga_colour hold their last values when vga_plot=0.
// CONFIGURATION
//  GAME_OVER_TINT_EN defined: if snapshot game_over=1, sky pixels are 3'b101
//   (magenta) instead of 3'b001. All other colours are unchanged.
//  Not defined: game_over is ignored; the sky is always 3'b001.
// TESTING
//  1. clr=1 for 2 cycles, then frame_tick
//     -> first plot 2 cycles later at (0,0); 19200 plots; done pulses once; busy low after.
//  2. bird_y=50, all pillars x=200
//     -> pixels x 30..35, y 50..55 are 3'b110; (36,50)=3'b001; (0,115)=3'b100.
//  3. pillar1_x=100, pillar1_y=40
//     -> (100,39)=3'b010; (100,40)..(100,79)=3'b001; (109,80)=3'b010;
//        (110,80)=3'b001; (100,110)=3'b100.
//  4. pillar1_x=155 -> columns 155..159 green outside gap; nothing wraps into column 0.
//  5. frame_tick 3 times during a frame, bird_y changed mid-frame
//     -> that frame uses old bird_y; exactly one extra frame follows; then IDLE.
//  6. clr asserted at pixel 5000 -> vga_plot, busy, done all 0 next cycle; no done pulse.
//     With GAME_OVER_TINT_EN and game_over=1 -> sky pixels 3'b101.

Source files
------------

// File: rtl/frame_painter.sv
// Raster painter: snapshots bird/pillar positions on a frame tick and emits one pixel write per cycle.
// Optional feature macro GAME_OVER_TINT_EN: sky is painted magenta when the snapshot game_over is set.
module frame_painter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int BIRD_X   = 30,
  parameter int BIRD_SZ  = 6,
  parameter int PILLAR_W = 10,
  parameter int GAP_H    = 40,
  parameter int GROUND_Y = 110
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic [9:0] bird_y,
  input  logic [9:0] pillar1_x,
  input  logic [9:0] pillar1_y,
  input  logic [9:0] pillar2_x,
  input  logic [9:0] pillar2_y,
  input  logic [9:0] pillar3_x,
  input  logic [9:0] pillar3_y,
  input  logic       game_over,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LATCH, SCAN, FLUSH} state_t;

  localparam logic [7:0]  X_LAST     = 8'(SCREEN_W - 1);
  localparam logic [6:0]  Y_LAST     = 7'(SCREEN_H - 1);
  localparam logic [10:0] BIRD_X_W   = 11'(BIRD_X);
  localparam logic [10:0] BIRD_SZ_W  = 11'(BIRD_SZ);
  localparam logic [10:0] PILLAR_W_W = 11'(PILLAR_W);
  localparam logic [10:0] GAP_H_W    = 11'(GAP_H);
  localparam logic [10:0] GROUND_Y_W = 11'(GROUND_Y);

  localparam logic [2:0] C_BIRD   = 3'b110;
  localparam logic [2:0] C_PILLAR = 3'b010;
  localparam logic [2:0] C_GROUND = 3'b100;
  localparam logic [2:0] C_SKY    = 3'b001;

  // 11-bit compare so that lo+len never wraps back onto low coordinates.
  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

  function automatic logic pillar_hit(input logic [10:0] x, input logic [10:0] y,
                                      input logic [9:0] px, input logic [9:0] py);
    return in_span(x, {1'b0, px}, PILLAR_W_W) && !in_span(y, {1'b0, py}, GAP_H_W) &&
           (y < GROUND_Y_W);
  endfunction

  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [9:0] bird_y_q, bird_y_d;
  logic [9:0] p1x_q, p1x_d, p1y_q, p1y_d;
  logic [9:0] p2x_q, p2x_d, p2y_q, p2y_d;
  logic [9:0] p3x_q, p3x_d, p3y_q, p3y_d;
  logic       game_over_q, game_over_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [10:0] x_s, y_s;
  logic        bird_hit_s, pillar_hit_s, ground_hit_s;
  logic [2:0]  sky_s, colour_s;

`ifdef GAME_OVER_TINT_EN
  assign sky_s = game_over_q ? 3'b101 : C_SKY;
`else
  logic unused_game_over_s;
  assign unused_game_over_s = game_over_q;
  assign sky_s = C_SKY;
`endif

  // Pixel colour for the current scan position, from the snapshot only.
  always_comb begin
    x_s          = {3'b000, cx_q};
    y_s          = {4'b0000, cy_q};
    bird_hit_s   = in_span(x_s, BIRD_X_W, BIRD_SZ_W) && in_span(y_s, {1'b0, bird_y_q}, BIRD_SZ_W);
    pillar_hit_s = pillar_hit(x_s, y_s, p1x_q, p1y_q) | pillar_hit(x_s, y_s, p2x_q, p2y_q) |
                   pillar_hit(x_s, y_s, p3x_q, p3y_q);
    ground_hit_s = (y_s >= GROUND_Y_W);
    if (bird_hit_s) begin
      colour_s = C_BIRD;
    end else if (pillar_hit_s) begin
      colour_s = C_PILLAR;
    end else if (ground_hit_s) begin
      colour_s = C_GROUND;
    end else begin
      colour_s = sky_s;
    end
  end

  // Next-state, scan counters, snapshot and output register inputs.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    bird_y_d     = bird_y_q;
    p1x_d        = p1x_q;
    p1y_d        = p1y_q;
    p2x_d        = p2x_q;
    p2y_d        = p2y_q;
    p3x_d        = p3x_q;
    p3y_d        = p3y_q;
    game_over_d  = game_over_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (frame_tick || pending_q) begin
          state_d   = LATCH;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        pending_d   = pending_q | frame_tick;
        bird_y_d    = bird_y;
        p1x_d       = pillar1_x;
        p1y_d       = pillar1_y;
        p2x_d       = pillar2_x;
        p2y_d       = pillar2_y;
        p3x_d       = pillar3_x;
        p3y_d       = pillar3_y;
        game_over_d = game_over;
        cx_d        = 8'd0;
        cy_d        = 7'd0;
        busy_d      = 1'b1;
        state_d     = SCAN;
      end
      SCAN: begin
        pending_d    = pending_q | frame_tick;
        vga_x_d      = cx_q;
        vga_y_d      = cy_q;
        vga_colour_d = colour_s;
        vga_plot_d   = 1'b1;
        if (cx_q == X_LAST) begin
          cx_d = 8'd0;
          if (cy_q == Y_LAST) begin
            cy_d    = 7'd0;
            state_d = FLUSH;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      FLUSH: begin
        pending_d = pending_q | frame_tick;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      cx_q         <= 8'd0;
      cy_q         <= 7'd0;
      bird_y_q     <= 10'd0;
      p1x_q        <= 10'd0;
      p1y_q        <= 10'd0;
      p2x_q        <= 10'd0;
      p2y_q        <= 10'd0;
      p3x_q        <= 10'd0;
      p3y_q        <= 10'd0;
      game_over_q  <= 1'b0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      bird_y_q     <= bird_y_d;
      p1x_q        <= p1x_d;
      p1y_q        <= p1y_d;
      p2x_q        <= p2x_d;
      p2y_q        <= p2y_d;
      p3x_q        <= p3x_d;
      p3y_q        <= p3y_d;
      game_over_q  <= game_over_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: captures every plotted pixel into a frame image and checks
// latency, count, order, colours, pending-tick handling and mid-frame clear.
module tb_frame_painter;

  logic       clk = 1'b0;
  logic       clr, frame_tick, game_over;
  logic [9:0] bird_y, p1x, p1y, p2x, p2y, p3x, p3y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

`ifdef GAME_OVER_TINT_EN
  localparam logic [2:0] SKY_GO = 3'b101;
`else
  localparam logic [2:0] SKY_GO = 3'b001;
`endif

  frame_painter dut (
    .clk(clk), .clr(clr), .frame_tick(frame_tick), .bird_y(bird_y),
    .pillar1_x(p1x), .pillar1_y(p1y), .pillar2_x(p2x), .pillar2_y(p2y),
    .pillar3_x(p3x), .pillar3_y(p3y), .game_over(game_over),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame capture: expected scan order is row-major from (0,0).
  logic [2:0] frame_mem [0:19199];
  int nplots = 0;
  int ndone = 0;
  int order_err = 0;
  int pix_idx = 0;

  always @(posedge clk) begin
    #1;
    if (clr) begin
      pix_idx = 0;
    end else begin
      if (vga_plot) begin
        if (vga_x != 8'(pix_idx % 160) || vga_y != 7'(pix_idx / 160)) order_err++;
        frame_mem[pix_idx] = vga_colour;
        nplots++;
        pix_idx = (pix_idx == 19199) ? 0 : pix_idx + 1;
      end
      if (done) ndone++;
    end
  end

  function automatic logic [2:0] pix(input int x, input int y);
    return frame_mem[y * 160 + x];
  endfunction

  task automatic pulse_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, done}, 32'd1);
  endtask

  int p0, d0, o0, n;

  initial begin
    clr = 1'b1; frame_tick = 1'b0; game_over = 1'b0;
    bird_y = 10'd50;
    p1x = 10'd100; p1y = 10'd40;
    p2x = 10'd155; p2y = 10'd40;
    p3x = 10'd200; p3y = 10'd0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    check_eq("rst_plot", {31'd0, vga_plot}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_xyc", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);

    // Frame 1: latency, count, order and geometry.
    p0 = nplots; d0 = ndone; o0 = order_err;
    pulse_tick();
    @(negedge clk);
    check_eq("lat_plot_early", {31'd0, vga_plot}, 32'd0);
    check_eq("lat_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("lat_plot_first", {31'd0, vga_plot}, 32'd1);
    check_eq("first_xy", {17'd0, vga_x, vga_y}, 32'd0);
    wait_done("f1_done");
    check_eq("f1_plots", nplots - p0, 32'd19200);
    check_eq("f1_order", order_err - o0, 32'd0);
    check_eq("f1_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("f1_done_once", ndone - d0, 32'd1);
    check_eq("f1_plot_off", {31'd0, vga_plot}, 32'd0);
    check_eq("hold_xy", {17'd0, vga_x, vga_y}, {17'd0, 8'd159, 7'd119});
    check_eq("bird_tl", pix(30, 50), 3'b110);
    check_eq("bird_br", pix(35, 55), 3'b110);
    check_eq("bird_right", pix(36, 50), 3'b001);
    check_eq("bird_below", pix(30, 56), 3'b001);
    check_eq("bird_left", pix(29, 52), 3'b001);
    check_eq("ground_0_115", pix(0, 115), 3'b100);
    check_eq("sky_0_0", pix(0, 0), 3'b001);
    check_eq("p1_above_gap", pix(100, 39), 3'b010);
    check_eq("p1_gap_top", pix(100, 40), 3'b001);
    check_eq("p1_gap_bot", pix(100, 79), 3'b001);
    check_eq("p1_below_gap", pix(109, 80), 3'b010);
    check_eq("p1_right_edge", pix(110, 80), 3'b001);
    check_eq("p1_last_row", pix(100, 109), 3'b010);
    check_eq("p1_ground", pix(100, 110), 3'b100);
    check_eq("p2_left", pix(155, 0), 3'b010);
    check_eq("p2_right", pix(159, 0), 3'b010);
    check_eq("p2_gap", pix(159, 50), 3'b001);
    check_eq("p2_before", pix(154, 0), 3'b001);
    check_eq("p2_nowrap", pix(4, 0), 3'b001);

    // Frames C/D: mid-frame input change plus three ticks -> exactly one extra frame.
    game_over = 1'b1;
    p0 = nplots; d0 = ndone;
    pulse_tick();
    repeat (100) @(negedge clk);
    bird_y = 10'd20;
    game_over = 1'b0;
    pulse_tick();
    repeat (50) @(negedge clk);
    pulse_tick();
    repeat (3000) @(negedge clk);
    pulse_tick();
    wait_done("c_done");
    check_eq("c_old_bird", pix(30, 50), 3'b110);
    check_eq("c_sky_tint", pix(0, 0), SKY_GO);
    check_eq("c_sky_at_new", pix(30, 20), SKY_GO);
    check_eq("c_ground", pix(0, 115), 3'b100);
    @(negedge clk);
    check_eq("pend_latch_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("pend_start_busy", {31'd0, busy}, 32'd1);
    wait_done("d_done");
    check_eq("d_new_bird", pix(30, 20), 3'b110);
    check_eq("d_old_bird_gone", pix(30, 50), 3'b001);
    check_eq("d_sky", pix(0, 0), 3'b001);
    repeat (30) @(negedge clk);
    check_eq("cd_two_frames", ndone - d0, 32'd2);
    check_eq("cd_plots", nplots - p0, 32'd38400);
    check_eq("cd_idle_busy", {31'd0, busy}, 32'd0);

    // Abort mid-frame with clr at pixel 5000.
    pulse_tick();
    n = 0;
    while (pix_idx < 5000 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_reach", pix_idx, 32'd5000);
    d0 = ndone;
    clr = 1'b1;
    @(negedge clk);
    check_eq("abort_plot", {31'd0, vga_plot}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    clr = 1'b0;
    p0 = nplots;
    repeat (100) @(negedge clk);
    check_eq("abort_no_done", ndone - d0, 32'd0);
    check_eq("abort_no_plots", nplots - p0, 32'd0);
    check_eq("abort_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
